// File: rtl/uart_bcd_pkg.sv
// Shared types and constants for the BCD-to-ASCII UART sender.
// ASCII codes, terminator modes, FSM states and digit encoding.
package uart_bcd_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int TERM_NONE = 0;
  localparam int TERM_LF   = 1;
  localparam int TERM_CRLF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_NEXT
  } tx_state_t;

  function automatic logic [7:0] bcd_to_ascii(
    input logic [3:0] nib
  );
    if (nib <= 4'd9) begin
      return ASCII_ZERO | {4'h0, nib};
    end
    return ASCII_QMARK;
  endfunction

endpackage

// File: rtl/uart_tx_bcd_n_byte.sv
// 8N1/8N2 byte serialiser; bits change only on baud_x1 edges.
// Ports: clk, reset, baud_x1_i, byte_i, byte_strobe_i, byte_ready_o,
//        frame_end_o (last stop bit ends, nothing queued), serial_o.
module uart_tx_byte
  import uart_bcd_pkg::*;
#(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_x1_i,
  input  logic [7:0] byte_i,
  input  logic       byte_strobe_i,
  output logic       byte_ready_o,
  output logic       frame_end_o,
  output logic       serial_o
);

  tx_state_t   state_q, state_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_q, bit_d;
  logic [0:0]  stop_q, stop_d;
  logic        pend_q, pend_d;
  logic [7:0]  pbyte_q, pbyte_d;
  logic        serial_q, serial_d;

  logic        last_stop;
  logic        take;
  logic        have;
  logic [7:0]  nxt_byte;

  assign last_stop = (state_q == ST_STOP) &&
                     (stop_q == 1'(STOP_BITS - 1));
  // A byte may be handed over while idle or during the
  // final stop bit, so frames run back-to-back.
  assign byte_ready_o = !pend_q &&
                        ((state_q == ST_IDLE) || last_stop);
  assign take     = byte_strobe_i && byte_ready_o;
  assign have     = pend_q || take;
  assign nxt_byte = pend_q ? pbyte_q : byte_i;
  assign serial_o = serial_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sh_q     <= '0;
      bit_q    <= '0;
      stop_q   <= '0;
      pend_q   <= 1'b0;
      pbyte_q  <= '0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      pend_q   <= pend_d;
      pbyte_q  <= pbyte_d;
      serial_q <= serial_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    pend_d      = pend_q;
    pbyte_d     = pbyte_q;
    serial_d    = serial_q;
    frame_end_o = 1'b0;

    // Hold a byte handed over between baud strobes.
    if (take && !baud_x1_i) begin
      pend_d  = 1'b1;
      pbyte_d = byte_i;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (baud_x1_i && have) begin
          state_d  = ST_START;
          serial_d = 1'b0;
          sh_d     = nxt_byte;
          pend_d   = 1'b0;
        end
      end
      ST_START: begin
        if (baud_x1_i) begin
          state_d  = ST_DATA;
          serial_d = sh_q[0];
          sh_d     = {1'b0, sh_q[7:1]};
          bit_d    = '0;
        end
      end
      ST_DATA: begin
        if (baud_x1_i) begin
          if (bit_q == 3'd7) begin
            state_d  = ST_STOP;
            serial_d = 1'b1;
            stop_d   = '0;
          end else begin
            serial_d = sh_q[0];
            sh_d     = {1'b0, sh_q[7:1]};
            bit_d    = bit_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (baud_x1_i) begin
          if (last_stop) begin
            if (have) begin
              state_d  = ST_START;
              serial_d = 1'b0;
              sh_d     = nxt_byte;
              pend_d   = 1'b0;
            end else begin
              state_d     = ST_IDLE;
              frame_end_o = 1'b1;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx_bcd_n.sv
// Prints packed BCD as ASCII over UART, MSD first, plus terminator.
// Ports: clk, reset, baud_x1, data, data_strobe, ready, serial.
// `define UART_BCD_ZERO_SUPPRESS_EN prints leading zeros as spaces.
module uart_tx_bcd_n
  import uart_bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int STOP_BITS  = 1,
  parameter int TERM_MODE  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    baud_x1,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    data_strobe,
  output logic                    ready,
  output logic                    serial
);

  localparam int TOTAL = NUM_DIGITS + TERM_MODE;
  localparam int IW    = $clog2(TOTAL + 1);

  localparam logic [IW-1:0] ND      = IW'(NUM_DIGITS);
  localparam logic [IW-1:0] ND_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] NT      = IW'(TOTAL);

`ifdef UART_BCD_ZERO_SUPPRESS_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  tx_state_t               state_q, state_d;
  logic [4*NUM_DIGITS-1:0] data_q, data_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    lead_q, lead_d;

  logic [3:0] nib;
  logic       is_digit;
  logic [7:0] chr;
  logic       byte_strobe;
  logic       byte_ready;
  logic       frame_end;
  logic       byte_take;

  assign ready       = (state_q == ST_IDLE);
  assign is_digit    = (idx_q < ND);
  assign byte_strobe = (state_q == ST_NEXT) && (idx_q != NT);
  assign byte_take   = byte_strobe && byte_ready;

  always_comb begin
    nib = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(NUM_DIGITS - 1 - k)) begin
        nib = data_q[4*k +: 4];
      end
    end
  end

  // Character selection: digits first, then terminator bytes.
  always_comb begin
    chr = ASCII_LF;
    if (is_digit) begin
      if (ZS && lead_q && (nib == 4'h0) &&
          (idx_q != ND_LAST)) begin
        chr = ASCII_SPACE;
      end else begin
        chr = bcd_to_ascii(nib);
      end
    end else if ((TERM_MODE == TERM_CRLF) &&
                 (idx_q == ND)) begin
      chr = ASCII_CR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      lead_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      lead_q  <= lead_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    lead_d  = lead_q;
    unique case (state_q)
      ST_IDLE: begin
        if (data_strobe) begin
          state_d = ST_NEXT;
          data_d  = data;
          idx_d   = '0;
          lead_d  = 1'b1;
        end
      end
      ST_NEXT: begin
        if (byte_take) begin
          idx_d = idx_q + 1'b1;
          // Invalid nibbles count as nonzero too.
          if (is_digit && (nib != 4'h0)) begin
            lead_d = 1'b0;
          end
        end
        if (frame_end) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  uart_tx_byte #(
    .STOP_BITS (STOP_BITS)
  ) u_byte (
    .clk           (clk),
    .reset         (reset),
    .baud_x1_i     (baud_x1),
    .byte_i        (chr),
    .byte_strobe_i (byte_strobe),
    .byte_ready_o  (byte_ready),
    .frame_end_o   (frame_end),
    .serial_o      (serial)
  );

endmodule

// File: tb/tb_uart_tx_bcd_n.sv
// Directed bench for uart_tx_bcd_n over three parameter sets.
// Decodes serial at baud edges and compares with hand-built bytes.
module tb_uart_tx_bcd_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        baud_x1 = 1'b0;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic [3:0]  data2 = '0;
  logic        stb0 = 1'b0;
  logic        stb1 = 1'b0;
  logic        stb2 = 1'b0;
  logic        rdy0, rdy1, rdy2;
  logic        ser0, ser1, ser2;

  int checks = 0;
  int errors = 0;

`ifdef UART_BCD_ZERO_SUPPRESS_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  uart_tx_bcd_n #(.NUM_DIGITS(8), .STOP_BITS(1),
                  .TERM_MODE(2)) u0 (
    .clk(clk), .reset(reset), .baud_x1(baud_x1),
    .data(data0), .data_strobe(stb0),
    .ready(rdy0), .serial(ser0));

  uart_tx_bcd_n #(.NUM_DIGITS(8), .STOP_BITS(1),
                  .TERM_MODE(0)) u1 (
    .clk(clk), .reset(reset), .baud_x1(baud_x1),
    .data(data1), .data_strobe(stb1),
    .ready(rdy1), .serial(ser1));

  uart_tx_bcd_n #(.NUM_DIGITS(1), .STOP_BITS(2),
                  .TERM_MODE(2)) u2 (
    .clk(clk), .reset(reset), .baud_x1(baud_x1),
    .data(data2), .data_strobe(stb2),
    .ready(rdy2), .serial(ser2));

  always #5 clk = ~clk;

  // baud_x1 high for one clk out of every four
  int bcnt = 0;
  always @(negedge clk) begin
    bcnt = (bcnt == 3) ? 0 : bcnt + 1;
    baud_x1 = (bcnt == 0);
  end

  logic [7:0] rx[$];
  logic       bits[$];
  int         nb;
  int         ferr;

  function automatic logic ser(input int d);
    case (d)
      0: return ser0;
      1: return ser1;
      default: return ser2;
    endcase
  endfunction

  function automatic logic rdy(input int d);
    case (d)
      0: return rdy0;
      1: return rdy1;
      default: return rdy2;
    endcase
  endfunction

  task automatic drive(input int d, input logic [31:0] v,
                       input logic s);
    case (d)
      0: begin data0 = v; stb0 = s; end
      1: begin data1 = v; stb1 = s; end
      default: begin data2 = v[3:0]; stb2 = s; end
    endcase
  endtask

  function automatic string hexq(input logic [7:0] q[$]);
    string s = "";
    foreach (q[k]) s = {s, $sformatf("%02h ", q[k])};
    return s;
  endfunction

  function automatic int diff_bytes(input logic [7:0] e[$]);
    int n = 0;
    if (rx.size() != e.size()) n++;
    for (int k = 0; k < e.size() && k < rx.size(); k++)
      if (rx[k] !== e[k]) n++;
    return n;
  endfunction

  // One transfer on DUT d. rst_at>0 asserts reset once that
  // many baud periods of the frame have elapsed and returns.
  task automatic xfer(input int d, input logic [31:0] v,
                      input bit hammer, input int rst_at);
    int   sb;
    bit   started;
    bit   done;
    logic prev;
    logic b, s, r;
    int   i;
    logic [7:0] by;
    sb = (d == 2) ? 2 : 1;
    started = 0;
    done = 0;
    prev = 1'b1;
    rx.delete();
    bits.delete();
    nb = 0;
    ferr = 0;
    @(posedge clk); #1;
    drive(d, v, 1'b1);
    @(posedge clk); #1;
    if (hammer) drive(d, $urandom, 1'b1);
    else drive(d, v, 1'b0);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      b = baud_x1;
      s = ser(d);
      r = rdy(d);
      if (!b && (s !== prev)) ferr++;
      prev = s;
      if (b && started) nb++;
      if (b && (started || s == 1'b0)) begin
        started = 1;
        bits.push_back(s);
      end
      if (rst_at > 0 && nb == rst_at) begin
        reset = 1'b1;
        drive(d, v, 1'b0);
        return;
      end
      if (r) begin
        drive(d, v, 1'b0);
        done = 1;
        break;
      end
      if (hammer) drive(d, $urandom, 1'b1);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout dut%0d ready got 0 want 1", d);
    end
    i = 0;
    while (i < bits.size()) begin
      if (bits[i] === 1'b1) begin
        i++;
      end else begin
        if (i + 8 + sb >= bits.size()) begin
          ferr++;
          break;
        end
        for (int j = 0; j < 8; j++) by[j] = bits[i+1+j];
        for (int j = 0; j < sb; j++)
          if (bits[i+9+j] !== 1'b1) ferr++;
        rx.push_back(by);
        i += 9 + sb;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ser(d) !== 1'b1) begin
        errors++;
        $display("FAIL reset_serial dut%0d got %b want 1",
                 d, ser(d));
      end
      checks++;
      if (rdy(d) !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready dut%0d got %b want 1",
                 d, rdy(d));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_digits();
    logic [7:0] e[$];
    if (ZS) e = '{8'h20, 8'h20, 8'h20, 8'h31, 8'h32,
                  8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A};
    else    e = '{8'h30, 8'h30, 8'h30, 8'h31, 8'h32,
                  8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A};
    xfer(0, 32'h0001_2345, 0, 0);
    checks++;
    if (diff_bytes(e) != 0) begin
      errors++;
      $display("FAIL digits got %s want %s",
               hexq(rx), hexq(e));
    end
    checks++;
    if (nb != 100) begin
      errors++;
      $display("FAIL digits_busy got %0d want 100", nb);
    end
    checks++;
    if (ferr != 0) begin
      errors++;
      $display("FAIL digits_framing got %0d want 0", ferr);
    end
  endtask

  task automatic test_zero();
    logic [7:0] e[$];
    if (ZS) e = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20,
                  8'h20, 8'h20, 8'h30, 8'h0D, 8'h0A};
    else    e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
                  8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    xfer(0, 32'h0, 0, 0);
    checks++;
    if (diff_bytes(e) != 0) begin
      errors++;
      $display("FAIL zero got %s want %s",
               hexq(rx), hexq(e));
    end
  endtask

  task automatic test_invalid();
    logic [7:0] e[$];
    if (ZS) e = '{8'h20, 8'h20, 8'h20, 8'h20,
                  8'h20, 8'h20, 8'h3F, 8'h39};
    else    e = '{8'h30, 8'h30, 8'h30, 8'h30,
                  8'h30, 8'h30, 8'h3F, 8'h39};
    xfer(1, 32'h0000_00A9, 0, 0);
    checks++;
    if (diff_bytes(e) != 0) begin
      errors++;
      $display("FAIL invalid got %s want %s",
               hexq(rx), hexq(e));
    end
    checks++;
    if (nb != 80) begin
      errors++;
      $display("FAIL invalid_busy got %0d want 80", nb);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e[$];
    int bad;
    e = '{8'h38, 8'h37, 8'h36, 8'h35, 8'h34,
          8'h33, 8'h32, 8'h31, 8'h0D, 8'h0A};
    xfer(0, 32'h8765_4321, 1, 0);
    checks++;
    if (diff_bytes(e) != 0) begin
      errors++;
      $display("FAIL hammer got %s want %s",
               hexq(rx), hexq(e));
    end
    checks++;
    if (nb != 100) begin
      errors++;
      $display("FAIL hammer_busy got %0d want 100", nb);
    end
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ser0 !== 1'b1 || rdy0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_queue got %0d busy cycles want 0",
               bad);
    end
  endtask

  task automatic test_stop2();
    logic [7:0] e[$];
    logic eb[11];
    int bad;
    e  = '{8'h37, 8'h0D, 8'h0A};
    eb = '{0, 1, 1, 1, 0, 1, 1, 0, 0, 1, 1};
    xfer(2, 32'h7, 0, 0);
    bad = 0;
    for (int k = 0; k < 11; k++)
      if (k >= bits.size() || bits[k] !== eb[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stop2_bits got %0d wrong bits want 0",
               bad);
    end
    checks++;
    if (diff_bytes(e) != 0) begin
      errors++;
      $display("FAIL stop2 got %s want %s",
               hexq(rx), hexq(e));
    end
    checks++;
    if (nb != 33) begin
      errors++;
      $display("FAIL stop2_busy got %0d want 33", nb);
    end
    checks++;
    if (ferr != 0) begin
      errors++;
      $display("FAIL stop2_framing got %0d want 0", ferr);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e[$];
    e = '{8'h39, 8'h38, 8'h37, 8'h36, 8'h35,
          8'h34, 8'h33, 8'h32, 8'h0D, 8'h0A};
    xfer(0, 32'h0001_2345, 0, 24);
    @(posedge clk); #1;
    checks++;
    if (ser0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_serial got %b want 1", ser0);
    end
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready got %b want 1", rdy0);
    end
    reset = 1'b0;
    xfer(0, 32'h9876_5432, 0, 0);
    checks++;
    if (diff_bytes(e) != 0) begin
      errors++;
      $display("FAIL after_abort got %s want %s",
               hexq(rx), hexq(e));
    end
    checks++;
    if (nb != 100) begin
      errors++;
      $display("FAIL after_abort_busy got %0d want 100", nb);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_zero();
    test_invalid();
    test_back_to_back();
    test_stop2();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
